// File: rtl/nios_system_processor_cpu_debug_ocimem_seq.sv
// System-clock sequencer turning JTAG debug strobes into reads/writes of the monitor RAM.
// Optional write-verify re-read is enabled by defining OCIMEM_WRITE_VERIFY_EN.
module nios_system_processor_cpu_debug_ocimem_seq #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int unsigned ADDR_LSB     = 26;
  localparam int unsigned DATA_LSB     = 3;
  localparam int unsigned CTL_SET_ADDR = 17;
  localparam int unsigned CTL_CLR_ERR  = 25;
  localparam int unsigned CTL_GO       = 34;

`ifdef OCIMEM_WRITE_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WR, RD, CAP, VRD, VCAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, WR, RD, CAP} state_t;
`endif

  state_t state;
  logic   prefetch;
  logic   idle_c;
  logic   err_set_c;
  logic   err_clr_c;
  logic   unused_jdo;

  // Not every jdo bit carries meaning for this block.
  assign unused_jdo = ^jdo;

  // Error set/clear decode; a set in the same cycle always beats a clear.
  always_comb begin
    idle_c    = (state == IDLE);
    err_set_c = 1'b0;
    err_clr_c = 1'b0;
    if (idle_c) begin
      err_set_c = (take_action_ocimem_b & (take_action_ocimem_a | take_no_action_ocimem_a))
                | (take_action_ocimem_a & take_no_action_ocimem_a);
      err_clr_c = take_action_ocimem_a & ~take_action_ocimem_b & jdo[CTL_CLR_ERR];
    end else begin
      err_set_c = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    end
`ifdef OCIMEM_WRITE_VERIFY_EN
    if ((state == VCAP) && (ram_rdata != ram_wdata)) err_set_c = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      prefetch      <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      ram_we        <= 1'b0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      ram_we        <= 1'b0;
      monitor_error <= err_set_c | (monitor_error & ~err_clr_c);
      case (state)
        IDLE: begin
          if (take_action_ocimem_b) begin
            ram_wdata     <= jdo[DATA_LSB +: DATA_W];
            MonDReg       <= jdo[DATA_LSB +: DATA_W];
            ram_we        <= 1'b1;
            monitor_ready <= 1'b0;
            state         <= WR;
          end else if (take_action_ocimem_a) begin
            if (jdo[CTL_SET_ADDR]) ram_addr <= jdo[ADDR_LSB +: ADDR_W];
            if (jdo[CTL_GO]) begin
              prefetch      <= 1'b1;
              monitor_ready <= 1'b0;
              state         <= RD;
            end
          end else if (take_no_action_ocimem_a) begin
            prefetch      <= 1'b0;
            monitor_ready <= 1'b0;
            state         <= RD;
          end
        end
        WR: begin
`ifdef OCIMEM_WRITE_VERIFY_EN
          state <= VRD;
`else
          ram_addr      <= ram_addr + ADDR_W'(1);
          monitor_ready <= 1'b1;
          state         <= IDLE;
`endif
        end
        RD: state <= CAP;
        CAP: begin
          MonDReg <= ram_rdata;
          if (!prefetch) ram_addr <= ram_addr + ADDR_W'(1);
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end
`ifdef OCIMEM_WRITE_VERIFY_EN
        VRD: state <= VCAP;
        VCAP: begin
          ram_addr      <= ram_addr + ADDR_W'(1);
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end
`endif
        default: begin
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
